multi_clk_div: RTL and testbench
================================

MULTI_CLK_DIV -- requirements
Module: multi_clk_div

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- CHANNELS, 2, number of independent output channels.
- WIDTH, 8, divisor/counter width in bits.
- RESET_DIV, 0, divisor loaded into every channel at reset.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising-edge.
- rst, in, 1, synchronous active-high reset.
- en, in, CHANNELS, per-channel count enable.
- inv, in, CHANNELS, per-channel output polarity; 1 inverts.
- div_in, in, CHANNELS*WIDTH, packed divisors; channel k occupies bits [k*WIDTH +: WIDTH].
- load, in, CHANNELS, per-channel strobe that captures div_in.
- out_wire, out, CHANNELS, divided clock per channel.
- tick, out, CHANNELS, one-cycle pulse on each divided-clock rising edge.
REQ-003 The block SHALL use one clock, clk, and a synchronous, active-high reset, rst; no other clock or asynchronous path exists.

Function
REQ-004 Each channel SHALL hold a shadow divisor S, an active divisor A, a WIDTH-bit counter C and a phase bit Q.
- All four are registered.
- No state is shared between channels.
REQ-005 A channel SHALL take a toggle event in any cycle with en[k]=1 and C==A.
- On a toggle event: C<=0 and Q<=~Q.
- When en[k]=1 and C!=A: C<=C+1 and Q holds.
REQ-006 When en[k]=0, C and Q SHALL hold their values.
- A later re-enable resumes counting from the held C.
REQ-007 With active divisor D, Q SHALL toggle every D+1 enabled cycles.
- Full period is 2*(D+1) cycles; duty cycle is 50 %.
- D=0 gives clk/2.
- D=2^WIDTH-1 gives the maximum period, 2^(WIDTH+1) cycles.
- C SHALL never exceed A and never wraps.
REQ-008 load[k]=1 SHALL set S<=div_in[k].
- A new divisor reaches A only on a toggle event: A<=S at every toggle. This makes output edges glitch-free.
- If load[k]=1 in the same cycle as a toggle event, A SHALL take div_in[k] directly, bypassing S.
REQ-009 A load that does not coincide with a toggle SHALL NOT change C, Q or A in that cycle.
REQ-010 out_wire[k] SHALL equal Q XOR inv[k], combinationally.
- An inv change is visible in the same cycle.
- An inv change does not disturb C or Q.
REQ-011 tick[k] SHALL be registered.
- It is high for exactly the one cycle following a toggle event that sets Q to 1.
- It is independent of inv[k].
REQ-012 Once the first toggle event has occurred, Q SHALL always be 0 or toggle within D+1 enabled cycles, for every reachable state.

Reset
REQ-013 While rst=1 (sampled at a clk edge), every channel SHALL take C=0, Q=0, S=RESET_DIV, A=RESET_DIV and tick=0.
- out_wire[k] therefore equals inv[k] during and directly after reset.
REQ-014 rst SHALL take priority over en, load and any pending toggle.
- A reset mid-period discards the partial count.
- A reset discards any unpromoted shadow divisor.
REQ-015 After rst falls, with en[k]=1 held and D=RESET_DIV, Q SHALL rise on the (D+1)-th rising clk edge.
- tick[k] is high in the cycle following that edge.

Verification
REQ-016 Directed scenarios the bench SHALL cover, one per line: stimulus -> required response with concrete values.
- WIDTH=8, RESET_DIV=0, en=2'b11, inv=2'b10 after reset -> out_wire[0] toggles every cycle; out_wire[1] is its complement; tick[0] pulses every 2nd cycle.
- load ch0 with div_in=3, then run 40 cycles -> the old divisor completes its current half-period; afterwards the period is 8 cycles, high/low 4/4, with no runt pulse.
- load coinciding with a toggle, div 1->5 -> the very next half-period is 6 cycles.
- en[0] low for 7 cycles mid-count with D=4, then high -> out_wire[0] and C frozen; the half-period resumes and completes with 5 total enabled cycles.
- div_in=255 -> half-period 256 cycles; C reaches 255 and never 0 early.
- rst asserted mid-period with Q=1, held 1 cycle -> next cycle C=0, Q=0, tick=0, out_wire=inv, A=RESET_DIV; a shadow loaded before reset is lost.

Source files
------------

// File: rtl/multi_clk_div.sv
// multi_clk_div: a bank of independent programmable clock dividers.
// Each channel counts enabled clk cycles and flips a phase bit after every
// (active divisor + 1) of them, so the divided output has a 50 % duty cycle.
// A newly loaded divisor is only adopted on a phase flip, which keeps every
// output edge glitch-free and prevents runt pulses.
module multi_clk_div #(
    parameter int CHANNELS  = 2,
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       inv,
    input  logic [CHANNELS*WIDTH-1:0] div_in,
    input  logic [CHANNELS-1:0]       load,
    output logic [CHANNELS-1:0]       out_wire,
    output logic [CHANNELS-1:0]       tick
);

    // Reset divisor truncated to the counter width once, here.
    localparam logic [WIDTH-1:0] RESET_DIV_W = WIDTH'(RESET_DIV);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            // Per-channel state; nothing is shared across channels.
            logic [WIDTH-1:0] shadow_reg, shadow_next;
            logic [WIDTH-1:0] active_reg, active_next;
            logic [WIDTH-1:0] cnt_reg, cnt_next;
            logic             q_reg, q_next;
            logic             tick_reg, tick_next;
            logic [WIDTH-1:0] div_k;
            logic             toggle;

            assign div_k  = div_in[gi*WIDTH +: WIDTH];
            // A half-period ends when an enabled cycle finds the counter at
            // the active divisor; the counter therefore never passes it.
            assign toggle = en[gi] && (cnt_reg == active_reg);

            // Next-state: count, flip phase, promote divisor on flips only.
            always_comb begin
                shadow_next = shadow_reg;
                active_next = active_reg;
                cnt_next    = cnt_reg;
                q_next      = q_reg;
                tick_next   = 1'b0;
                if (load[gi]) begin
                    shadow_next = div_k;
                end
                if (toggle) begin
                    cnt_next    = '0;
                    q_next      = ~q_reg;
                    // Tick marks the rising phase edge only, regardless of inv.
                    tick_next   = ~q_reg;
                    // A load landing on the flip itself takes effect at once.
                    active_next = load[gi] ? div_k : shadow_reg;
                end else if (en[gi]) begin
                    cnt_next = cnt_reg + WIDTH'(1);
                end
            end

            // State register; reset wins over enable, load and pending flips.
            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_reg <= RESET_DIV_W;
                    active_reg <= RESET_DIV_W;
                    cnt_reg    <= '0;
                    q_reg      <= 1'b0;
                    tick_reg   <= 1'b0;
                end else begin
                    shadow_reg <= shadow_next;
                    active_reg <= active_next;
                    cnt_reg    <= cnt_next;
                    q_reg      <= q_next;
                    tick_reg   <= tick_next;
                end
            end

            // Polarity is applied after the register so inv acts immediately
            // and never disturbs the phase or count.
            assign out_wire[gi] = q_reg ^ inv[gi];
            assign tick[gi]     = tick_reg;
        end
    endgenerate

endmodule

// File: tb/tb_multi_clk_div.sv
// Testbench for multi_clk_div: directed scenarios followed by a random phase,
// all compared every cycle against a "cycles left in this half-period" model.
module tb_multi_clk_div;

    localparam int CH = 2;
    localparam int W  = 8;
    localparam int RD = 0;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   en;
    logic [CH-1:0]   inv;
    logic [CH-1:0]   load;
    logic [CH*W-1:0] div_in;
    wire  [CH-1:0]   out_wire;
    wire  [CH-1:0]   tick;

    int checks   = 0;
    int failures = 0;

    // Reference model: enabled cycles remaining before the next phase flip.
    int left_m [CH];
    int shad_m [CH];
    int act_m  [CH];
    bit q_m    [CH];
    bit tick_m [CH];

    int   n;
    logic v;

    always #5 clk = ~clk;

    multi_clk_div #(
        .CHANNELS (CH),
        .WIDTH    (W),
        .RESET_DIV(RD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .inv     (inv),
        .div_in  (div_in),
        .load    (load),
        .out_wire(out_wire),
        .tick    (tick)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then
    // compare every output against it.
    task automatic cycle();
        logic [CH-1:0]   en_s;
        logic [CH-1:0]   ld_s;
        logic [CH*W-1:0] d_s;
        logic            r_s;
        int              dk;
        en_s = en;
        ld_s = load;
        d_s  = div_in;
        r_s  = rst;
        @(posedge clk);
        for (int k = 0; k < CH; k++) begin
            dk = int'(d_s[k*W +: W]);
            if (r_s) begin
                left_m[k] = RD + 1;
                q_m[k]    = 1'b0;
                tick_m[k] = 1'b0;
                shad_m[k] = RD;
                act_m[k]  = RD;
            end else begin
                tick_m[k] = 1'b0;
                if (en_s[k]) begin
                    left_m[k]--;
                    if (left_m[k] == 0) begin
                        q_m[k]    = !q_m[k];
                        tick_m[k] = q_m[k];
                        act_m[k]  = ld_s[k] ? dk : shad_m[k];
                        left_m[k] = act_m[k] + 1;
                    end
                end
                if (ld_s[k]) shad_m[k] = dk;
            end
        end
        #1;
        for (int k = 0; k < CH; k++) begin
            check_bit($sformatf("out_wire[%0d]", k), out_wire[k], q_m[k] ^ inv[k]);
            check_bit($sformatf("tick[%0d]", k), tick[k], tick_m[k]);
        end
    endtask

    // Count cycles until out_wire[k] next changes, bounded by limit.
    task automatic half_period(input int k, input int limit, output int cnt);
        logic prev;
        prev = out_wire[k];
        cnt  = 0;
        do begin
            cycle();
            cnt++;
        end while (out_wire[k] === prev && cnt < limit);
        $display("half-period ch%0d = %0d cycles", k, cnt);
    endtask

    initial begin
        // Reset with inv=2'b10: outputs must equal inv, ticks low.
        rst = 1'b1; en = '0; inv = 2'b10; load = '0; div_in = '0;
        cycle();
        cycle();
        check_int("reset_out_wire", int'(out_wire), 2);
        check_int("reset_tick", int'(tick), 0);
        $display("reset applied, out_wire=%b tick=%b", out_wire, tick);

        // D=0 on both channels: clk/2, ch1 complementary via inv.
        rst = 1'b0; en = 2'b11;
        cycle();
        check_bit("first_rise_q0", out_wire[0], 1'b1);
        check_bit("first_rise_tick0", tick[0], 1'b1);
        for (int i = 0; i < 8; i++) begin
            cycle();
            check_bit("complement", out_wire[1], ~out_wire[0]);
        end
        $display("clk/2 run done");

        // Load 3 on ch0; with D=0 it lands on a flip, so 4/4 follows.
        div_in = {8'd0, 8'd3}; load = 2'b01;
        cycle();
        load = '0;
        for (int i = 0; i < 5; i++) begin
            half_period(0, 20, n);
            check_int("div3_half", n, 4);
        end

        // Load 1 mid half-period: old divisor finishes its 4 cycles.
        cycle();
        div_in = {8'd0, 8'd1}; load = 2'b01;
        cycle();
        load = '0;
        half_period(0, 20, n);
        check_int("div3_finish", n, 2);
        half_period(0, 20, n);
        check_int("div1_half", n, 2);

        // Load 5 exactly on a flip: next half-period is 6 cycles.
        cycle();
        v = out_wire[0];
        div_in = {8'd0, 8'd5}; load = 2'b01;
        cycle();
        load = '0;
        check_bit("coincident_flip", out_wire[0], ~v);
        for (int i = 0; i < 2; i++) begin
            half_period(0, 20, n);
            check_int("div5_half", n, 6);
        end

        // D=4, then freeze ch0 for 7 cycles two cycles into a half-period.
        div_in = {8'd0, 8'd4}; load = 2'b01;
        cycle();
        load = '0;
        half_period(0, 20, n);
        check_int("div5_finish", n, 5);
        cycle();
        cycle();
        v = out_wire[0];
        en = 2'b10;
        for (int i = 0; i < 7; i++) begin
            cycle();
            check_bit("frozen", out_wire[0], v);
        end
        en = 2'b11;
        half_period(0, 20, n);
        check_int("resume_rest", n, 3);
        half_period(0, 20, n);
        check_int("div4_half", n, 5);

        // Maximum divisor: 256-cycle half-periods.
        div_in = {8'd0, 8'd255}; load = 2'b01;
        cycle();
        load = '0;
        half_period(0, 20, n);
        check_int("div4_finish", n, 4);
        for (int i = 0; i < 2; i++) begin
            half_period(0, 300, n);
            check_int("div255_half", n, 256);
        end

        // Reset mid-period with Q=1 and a pending shadow divisor.
        if (out_wire[0] !== 1'b1) half_period(0, 300, n);
        inv = 2'b11;
        #1;
        check_bit("inv_immediate", out_wire[0], 1'b0);
        inv = 2'b10;
        #1;
        check_bit("inv_restore", out_wire[0], 1'b1);
        cycle();
        cycle();
        div_in = {8'd0, 8'd7}; load = 2'b01;
        cycle();
        load = '0;
        rst  = 1'b1;
        cycle();
        check_int("midreset_out_wire", int'(out_wire), 2);
        check_int("midreset_tick", int'(tick), 0);
        rst = 1'b0;
        cycle();
        check_bit("post_reset_rise", out_wire[0], 1'b1);
        check_bit("post_reset_tick", tick[0], 1'b1);
        for (int i = 0; i < 2; i++) begin
            half_period(0, 20, n);
            check_int("shadow_lost_half", n, 1);
        end
        $display("mid-period reset done");

        // Random phase: mixed enables, loads, polarity and rare resets.
        for (int i = 0; i < 600; i++) begin
            en     = ($urandom_range(0, 3) != 0) ? 2'b11 : CH'($urandom);
            load   = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
            div_in = {8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))};
            inv    = CH'($urandom);
            rst    = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;
        $display("random phase done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
